// File: rtl/arb_pkg.sv
// Shared arbiter definitions: state encoding and index helpers.
package arb_pkg;

    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_OWN  = 1'b1;

    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    function automatic logic [31:0] onehot2bin(input logic [31:0] oh);
        logic [31:0] b;
        b = '0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) begin
                b = b | 32'(i);
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner select: scans a doubled request vector starting
// just above ptr and folds the lowest hit back to N bits.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic [N-1:0]         excl_mask,
    output logic                 win_vld,
    output logic [N-1:0]         win_onehot,
    output logic [$clog2(N)-1:0] win_id
);

    localparam int W   = 2 * N;
    localparam int IDW = $clog2(N);

    logic [N-1:0] eff;
    logic [W-1:0] dbl;
    logic [W-1:0] msk;
    logic [W-1:0] masked;
    logic [W-1:0] lsb;

    always_comb begin
        eff    = req & ~excl_mask;
        dbl    = {eff, eff};
        // every index ptr+1 .. ptr+N lies above ptr in the doubled vector
        msk    = ({W{1'b1}} << ptr) << 1;
        masked = dbl & msk;
        lsb    = masked & (~masked + W'(1));
        win_onehot = lsb[N-1:0] | lsb[W-1:N];
        win_vld    = |masked;
        win_id     = IDW'(onehot2bin(32'(win_onehot)));
    end

endmodule

// File: rtl/arb_rr_n_lock.sv
// N-way round-robin arbiter with registered one-hot grant, optional
// ownership locking and a bounded hold time when others are waiting.
module arb_rr_n_lock
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int LOCK     = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic                 gnt_vld,
    output logic [$clog2(N)-1:0] gnt_id
);

    localparam int IDW = $clog2(N);
    localparam int CW  = clog2_min1(MAX_HOLD + 1);

    logic [0:0]     state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [CW-1:0]  hold_q, hold_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic           vld_q, vld_d;
    logic [IDW-1:0] id_q, id_d;

    logic [N-1:0]   owner_oh;
    logic           owner_req;
    logic           others;
    logic           at_max;
    logic           locked;
    logic           keep;
    logic           rotate;
    logic [N-1:0]   excl;

    logic           win_vld;
    logic [N-1:0]   win_onehot;
    logic [IDW-1:0] win_id;

    always_comb begin
        owner_oh  = N'(1) << ptr_q;
        owner_req = |(req & owner_oh);
        others    = |(req & ~owner_oh);
        at_max    = (MAX_HOLD != 0) && (hold_q == CW'(MAX_HOLD));
        locked    = (state_q == ARB_OWN) && (LOCK != 0) && owner_req;
        rotate    = locked && at_max && others;
        keep      = locked && !rotate;
        // only a forced rotation takes the owner out of the scan
        excl      = rotate ? owner_oh : '0;
    end

    rr_pick #(
        .N (N)
    ) u_pick (
        .req        (req),
        .ptr        (ptr_q),
        .excl_mask  (excl),
        .win_vld    (win_vld),
        .win_onehot (win_onehot),
        .win_id     (win_id)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        vld_d   = vld_q;
        id_d    = id_q;
        if (keep) begin
            if (at_max) begin
                hold_d = CW'(1);
            end else if (hold_q != {CW{1'b1}}) begin
                hold_d = hold_q + CW'(1);
            end
        end else if (win_vld) begin
            state_d = ARB_OWN;
            ptr_d   = win_id;
            hold_d  = CW'(1);
            gnt_d   = win_onehot;
            vld_d   = 1'b1;
            id_d    = win_id;
        end else begin
            state_d = ARB_IDLE;
            hold_d  = '0;
            gnt_d   = '0;
            vld_d   = 1'b0;
            id_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            ptr_q   <= IDW'(N - 1);
            hold_q  <= '0;
            gnt_q   <= '0;
            vld_q   <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            vld_q   <= vld_d;
            id_q    <= id_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_vld = vld_q;
    assign gnt_id  = id_q;

endmodule
